// File: rtl/cache_arbiter_pkg.sv
// Shared types and width constants for the I/D cache-miss arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package arb_types;

    localparam int ARB_BEATS  = 4;
    localparam int ARB_BEAT_W = 64;
    localparam int ARB_LINE_W = 256;

    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_RD,
        D_WR,
        DONE
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

    // Clear the byte-offset bits so the burst base lands on a line boundary.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & ~32'(ARB_LINE_W / 8 - 1);
    endfunction

endpackage

// File: rtl/line_burst_buffer.sv
// Line register plus beat counter: assembles read beats, serves write beats.
// Latency: read beat stored on the edge it arrives; write beat is combinational from the counter.
// Backpressure: counter advances only on an accepted/returned beat (i_beat_en).
module line_burst_buffer #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 64,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [LINE_W-1:0] i_load_line,
    input  logic              i_beat_en,
    input  logic              i_beat_wr,
    input  logic [BEAT_W-1:0] i_rbeat,
    output logic [LINE_W-1:0] o_line,
    output logic [BEAT_W-1:0] o_wbeat,
    output logic              o_last_beat
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CNT_W-1:0]  r_count;
    logic [LINE_W-1:0] r_line;
    logic              w_at_last;

    assign w_at_last   = (r_count == CNT_W'(BEATS - 1));
    assign o_last_beat = i_beat_en && w_at_last;
    assign o_line      = r_line;
    assign o_wbeat     = r_line[int'(r_count) * BEAT_W +: BEAT_W];

    // Beat counter wraps to 0 on the final beat so the next burst starts at slice 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_beat_en) begin
            r_count <= w_at_last ? '0 : r_count + CNT_W'(1);
        end
    end

    // Line register: whole-line load for writebacks, per-beat insert for fills.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_line <= '0;
        end else if (i_load) begin
            r_line <= i_load_line;
        end else if (i_beat_en && i_beat_wr) begin
            r_line[int'(r_count) * BEAT_W +: BEAT_W] <= i_rbeat;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Merges I-side fills and D-side fills/writebacks onto one burst memory port.
// Latency: request in IDLE at t -> strobe at t+1; last beat at u -> client resp at u+1.
// Backpressure: bursts pace on pmem_resp; clients hold requests until their resp pulse.
module cache_arbiter
    import arb_types::*;
#(
    parameter int BEATS  = ARB_BEATS,
    parameter int BEAT_W = ARB_BEAT_W,
    parameter int LINE_W = ARB_LINE_W   // must equal BEATS*BEAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [31:0]       i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [BEAT_W-1:0] pmem_wdata,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    grant_t     r_last_grant;
    grant_t     r_grant;
    grant_t     w_grant;
    logic       w_grant_vld;
    logic [31:0] r_addr;

    logic              w_i_pend;
    logic              w_d_pend;
    logic              w_rd_state;
    logic              w_wr_state;
    logic              w_beat_en;
    logic              w_load;
    logic              w_last_beat;
    logic [LINE_W-1:0] w_line;

    assign w_i_pend   = i_read;
    assign w_d_pend   = d_read || d_write;
    assign w_rd_state = (r_state == I_RD) || (r_state == D_RD);
    assign w_wr_state = (r_state == D_WR);

    // Beats only count inside a burst; stray pmem_resp elsewhere is dropped here.
    assign w_beat_en  = pmem_resp && (w_rd_state || w_wr_state);
    assign w_load     = w_grant_vld && (w_grant == GRANT_D) && d_write;

    assign pmem_read    = w_rd_state;
    assign pmem_write   = w_wr_state;
    assign pmem_address = r_addr;
    assign i_rdata      = w_line;
    assign d_rdata      = w_line;
    assign i_resp       = (r_state == DONE) && (r_grant == GRANT_I);
    assign d_resp       = (r_state == DONE) && (r_grant == GRANT_D);

    line_burst_buffer #(
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W),
        .LINE_W (LINE_W)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_load_line (d_wdata),
        .i_beat_en   (w_beat_en),
        .i_beat_wr   (w_rd_state),
        .i_rbeat     (pmem_rdata),
        .o_line      (w_line),
        .o_wbeat     (pmem_wdata),
        .o_last_beat (w_last_beat)
    );

    // State, grant history and latched line address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_I;
            r_grant      <= GRANT_I;
            r_addr       <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_vld) begin
                r_last_grant <= w_grant;
                r_grant      <= w_grant;
                r_addr       <= (w_grant == GRANT_I) ? line_align(i_addr) : line_align(d_addr);
            end
        end
    end

    // Round-robin arbitration in IDLE; burst states exit on the final beat.
    always_comb begin
        w_next_state = r_state;
        w_grant_vld  = 1'b0;
        w_grant      = GRANT_I;
        case (r_state)
            IDLE: begin
                if (w_i_pend && w_d_pend) begin
                    w_grant     = (r_last_grant == GRANT_I) ? GRANT_D : GRANT_I;
                    w_grant_vld = 1'b1;
                end else if (w_d_pend) begin
                    w_grant     = GRANT_D;
                    w_grant_vld = 1'b1;
                end else if (w_i_pend) begin
                    w_grant     = GRANT_I;
                    w_grant_vld = 1'b1;
                end
                if (w_grant_vld) begin
                    if (w_grant == GRANT_I) begin
                        w_next_state = I_RD;
                    end else if (d_write) begin
                        // read+write together is treated as a writeback
                        w_next_state = D_WR;
                    end else begin
                        w_next_state = D_RD;
                    end
                end
            end
            I_RD, D_RD, D_WR: begin
                if (w_last_beat) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_addr;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [63:0]  pmem_wdata;
    logic [63:0]  pmem_rdata;
    logic         pmem_resp;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_addr       (i_addr),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for the strobe, serves four beats with the given spacing, then checks the
    // DONE cycle and the IDLE bubble after it. Drops the served request at DONE.
    task automatic do_burst(input string tag, input bit wr, input logic [31:0] addr,
                            input logic [255:0] line, input bit to_i, input int gap);
        int waits;
        bit seen;
        waits = 0;
        seen  = 1'b0;
        for (int c = 0; c < 16 && !seen; c++) begin
            @(negedge clk);
            waits++;
            if (pmem_read || pmem_write) seen = 1'b1;
        end
        if (!seen) begin
            chk({tag, " strobe timeout"}, 0, 1);
            return;
        end
        chk({tag, " strobe latency"}, waits, 1);
        chk({tag, " pmem_read"}, pmem_read, !wr);
        chk({tag, " pmem_write"}, pmem_write, wr);
        chk({tag, " address"}, pmem_address, addr);
        for (int k = 0; k < 4; k++) begin
            for (int g = 1; g < gap; g++) begin
                @(negedge clk);
            end
            chk({tag, " strobe held"}, {pmem_read, pmem_write}, wr ? 2'b01 : 2'b10);
            pmem_resp  = 1'b1;
            pmem_rdata = line[k*64 +: 64];
            if (wr) chk({tag, " wbeat"}, pmem_wdata, line[k*64 +: 64]);
            @(negedge clk);
            pmem_resp  = 1'b0;
            pmem_rdata = '0;
        end
        chk({tag, " address stable"}, pmem_address, addr);
        chk({tag, " i_resp"}, i_resp, to_i);
        chk({tag, " d_resp"}, d_resp, !to_i);
        chk({tag, " rdata"}, to_i ? i_rdata : d_rdata, line);
        chk({tag, " strobe dropped"}, {pmem_read, pmem_write}, 2'b00);
        if (to_i) begin
            i_read = 1'b0;
        end else begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
        @(negedge clk);
        chk({tag, " resp pulse end"}, {i_resp, d_resp}, 2'b00);
        chk({tag, " idle bubble"}, {pmem_read, pmem_write}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] l_a, l_w, l_b, l_c;
        logic         seen;
        l_a = {64'h4444444444444444, 64'h3333333333333333,
               64'h2222222222222222, 64'h1111111111111111};
        l_w = {64'd4, 64'd3, 64'd2, 64'd1};
        l_b = {64'hBBBB000000000004, 64'hBBBB000000000003,
               64'hBBBB000000000002, 64'hBBBB000000000001};
        l_c = {64'hCCCC0000000000D4, 64'hCCCC0000000000D3,
               64'hCCCC0000000000D2, 64'hCCCC0000000000D1};

        rst = 1'b1; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
        d_addr = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
        do_reset();

        // Reset state
        chk("rst pmem_read", pmem_read, 0);
        chk("rst pmem_write", pmem_write, 0);
        chk("rst address", pmem_address, 0);
        chk("rst resp", {i_resp, d_resp}, 2'b00);
        chk("rst i_rdata", i_rdata, 0);
        chk("rst d_rdata", d_rdata, 0);

        // Single I read, 2-cycle beat spacing
        i_read = 1'b1; i_addr = 32'h0000_0064;
        do_burst("iread", 1'b0, 32'h0000_0060, l_a, 1'b1, 2);

        // D writeback
        d_write = 1'b1; d_addr = 32'h8000_0020; d_wdata = l_w;
        do_burst("dwrite", 1'b1, 32'h8000_0020, l_w, 1'b0, 1);

        // Read+write together resolves to a write
        d_read = 1'b1; d_write = 1'b1; d_addr = 32'h0000_1234; d_wdata = l_c;
        do_burst("rdwr", 1'b1, 32'h0000_1220, l_c, 1'b0, 1);

        // Tie after reset goes to D; I follows after DONE + IDLE
        do_reset();
        i_read = 1'b1; i_addr = 32'h0000_1000;
        d_read = 1'b1; d_addr = 32'h0000_2000;
        do_burst("tie d", 1'b0, 32'h0000_2000, l_b, 1'b0, 1);
        do_burst("tie i", 1'b0, 32'h0000_1000, l_a, 1'b1, 1);

        // Sustained contention alternates D, I, D, I
        do_reset();
        i_read = 1'b1; d_read = 1'b1;
        for (int t = 0; t < 4; t++) begin
            if (t % 2 == 0) begin
                do_burst("cont d", 1'b0, 32'h0000_2000, l_b, 1'b0, 1);
                d_read = 1'b1;
            end else begin
                do_burst("cont i", 1'b0, 32'h0000_1000, l_c, 1'b1, 1);
                i_read = 1'b1;
            end
        end
        i_read = 1'b0; d_read = 1'b0;
        @(negedge clk);

        // Reset mid-burst
        do_reset();
        i_read = 1'b1; i_addr = 32'h0000_0040;
        seen = 1'b0;
        for (int c = 0; c < 16 && !seen; c++) begin
            @(negedge clk);
            if (pmem_read) seen = 1'b1;
        end
        chk("midrst strobe", seen, 1);
        for (int k = 0; k < 2; k++) begin
            pmem_resp = 1'b1; pmem_rdata = l_a[k*64 +: 64];
            @(negedge clk);
            pmem_resp = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst pmem_read", pmem_read, 0);
        chk("midrst resp", {i_resp, d_resp}, 2'b00);
        chk("midrst i_rdata", i_rdata, 0);
        rst = 1'b0; i_read = 1'b0;
        @(negedge clk);
        chk("midrst no resp", {i_resp, d_resp}, 2'b00);
        // Stray beat while idle must not move the counter
        pmem_resp = 1'b1; pmem_rdata = 64'hDEAD;
        @(negedge clk);
        pmem_resp = 1'b0; pmem_rdata = '0;
        i_read = 1'b1; i_addr = 32'h0000_0080;
        do_burst("postrst", 1'b0, 32'h0000_0080, l_b, 1'b1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
Sits directly downstream of the cpu's I-side and D-side cache miss paths. Merges instruction-line and data-line requests onto the single physical-memory burst port. Each 256-bit line transfer is performed as a 4-beat, 64-bit burst. Fills are returned to the requesting client, and dirty-line writebacks are issued from the data side.

Parameters:
BEATS, 4, beats per line burst
BEAT_W, 64, physical memory data width in bits
LINE_W, 256, cache line width; must equal BEATS*BEAT_W

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_read  in  1  I-side line read request; held until i_resp
i_addr  in  32  I-side line address
i_rdata  out  LINE_W  line returned to I-side
i_resp  out  1  I-side completion pulse
d_read  in  1  D-side line read request
d_write  in  1  D-side line write request
d_addr  in  32  D-side line address
d_wdata  in  LINE_W  line to write
d_rdata  out  LINE_W  line returned to D-side
d_resp  out  1  D-side completion pulse
pmem_read  out  1  burst read request
pmem_write  out  1  burst write request
pmem_address  out  32  burst base address, line-aligned
pmem_wdata  out  BEAT_W  current write beat
pmem_rdata  in  BEAT_W  current read beat
pmem_resp  in  1  one beat accepted or returned this cycle

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state=IDLE, beat counter=0, line buffer=0, last_grant=I.
  - All outputs 0: pmem_read/write=0, pmem_address=0, i_resp/d_resp=0, i_rdata/d_rdata=0.
- FSM states: IDLE, I_RD, D_RD, D_WR, DONE.
- IDLE, arbitration:
  - A pending request is i_read, or (d_read|d_write).
  - Only one pending: grant it.
  - Both pending: grant the client opposite to last_grant. After reset, a tie goes to D.
  - On grant: latch the address as {addr[31:5],5'b0} and update last_grant.
  - Next state: D_WR if d_write, else D_RD for d_read, else I_RD.
  - If d_read and d_write are both set, treat it as a write.
  - On a D_WR grant, latch d_wdata into the line buffer.
- Burst states:
  - pmem_read (I_RD/D_RD) or pmem_write (D_WR) is held high from the first cycle in the state until the BEATS-th pmem_resp.
  - pmem_address is stable for the whole burst.
- Beat counter (2 bits) advances only on pmem_resp.
  - Read states: beat k writes buffer[64k+63:64k] <= pmem_rdata.
  - D_WR: pmem_wdata = buffer[64k+63:64k], combinational from the counter.
  - When pmem_resp arrives with counter==BEATS-1: counter wraps to 0 and state goes to DONE.
- DONE lasts exactly one cycle.
  - The granted client's resp is high; the other resp stays 0.
  - i_rdata and d_rdata both continuously drive the line buffer; resp qualifies validity.
  - Next state: IDLE.
- Latency:
  - Request seen in IDLE at cycle t gives pmem strobe at t+1.
  - Last pmem_resp at cycle u gives client resp at u+1.
  - One IDLE bubble separates consecutive bursts.
- Client protocol: hold the request and address stable until resp; drop it in the cycle after resp. The arbiter never samples a request in DONE.
- A request withdrawn mid-burst is a protocol violation. The burst still completes, and resp pulses anyway.
- pmem_resp outside burst states is ignored.
- rst asserted mid-burst: next cycle returns all state to reset values and drops strobes; no resp is issued.

Decomposition:
- Package arb_types:
  - arb_state_t enum (IDLE, I_RD, D_RD, D_WR, DONE).
  - grant_t enum (GRANT_I, GRANT_D).
  - Width constants for BEATS, BEAT_W, LINE_W.
- Sub-module line_burst_buffer: holds the line register and beat counter. Does beat insert/extract, and signals last_beat = pmem_resp && count==BEATS-1.
- The arbiter FSM stays in cache_arbiter.

Test Plan:
- Single I read:
  - Stimulus: i_read=1, i_addr=0x0000_0064; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with 2-cycle resp spacing.
  - Required: pmem_address=0x0000_0060; i_rdata={0x44..,0x33..,0x22..,0x11..}; i_resp is a 1-cycle pulse the cycle after beat 4; d_resp=0.
- D write:
  - Stimulus: d_write=1, d_addr=0x8000_0020, d_wdata=line with beat k = k+1.
  - Required: pmem_write held for 4 resps; pmem_wdata=1,2,3,4 in order; d_resp one cycle after the last beat.
- Tie after reset:
  - Stimulus: i_read and d_read asserted in the same cycle.
  - Required: D served first; I burst starts 2 cycles after d_resp (DONE then IDLE); i_resp follows.
- Sustained contention:
  - Stimulus: both clients re-request immediately after each resp for 4 transactions.
  - Required: grants alternate D, I, D, I.
- Reset mid-burst:
  - Stimulus: rst asserted after 2 of 4 read beats.
  - Required: next cycle pmem_read=0, no i_resp/d_resp; a fresh request after reset completes normally with counter starting at beat 0.
- Read+write conflict:
  - Stimulus: d_read=d_write=1.
  - Required: pmem_write issued, not pmem_read.
